// File: rtl/agu_sequencer.sv
// agu_sequencer: transfer-level controller for the AGU load/enable inputs.
// Takes one descriptor, presents it on latch_tr_*, pulses the generator
// ldinit strobes, then steps the selected generators for tr_length beats.
// Optional build macro: AGU_SEQ_CLEAR_EN adds a CLEAR state (clear_agu pulse)
// before LOAD, and a clear_agu pulse in DONE after an aborted transfer.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a descriptor, tr_ready high
// ST_CLEAR | one-cycle clear_agu pulse (AGU_SEQ_CLEAR_EN builds only)
// ST_LOAD  | one cycle, ldinit strobes for the selected generators
// ST_RUN   | enables asserted on every non-stalled beat until count hits 0
// ST_DONE  | one-cycle done pulse, aborted qualifies the cause

module agu_sequencer #(
   parameter int ADDR_W = 40,
   parameter int CTRL_W = 4,
   parameter int LEN_W  = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              tr_valid,
   output logic              tr_ready,
   input  logic [ADDR_W-1:0] tr_addresses,
   input  logic [CTRL_W-1:0] tr_control,
   input  logic [LEN_W-1:0]  tr_length,
   input  logic              agu_stall,
   input  logic              abort,
   output logic [ADDR_W-1:0] latch_tr_addresses,
   output logic [CTRL_W-1:0] latch_tr_control,
   output logic              mem_gen_ldinit,
   output logic              byte_gen_ldinit,
   output logic              rc_gen_ldinit,
   output logic              mem_gen_enable,
   output logic              byte_gen_enable,
   output logic              fb_gen_enable,
   output logic              rc_gen_enable,
   output logic              clear_agu,
   output logic              busy,
   output logic [LEN_W-1:0]  beats_left,
   output logic              done,
   output logic              aborted
);

`ifdef AGU_SEQ_CLEAR_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_out_en;
   logic                r_aborted;
   logic [ADDR_W-1:0]   r_latch_addr;
   logic [CTRL_W-1:0]   r_latch_ctrl;
   logic [LEN_W-1:0]    r_beats_left;
   logic [LEN_W-1:0]    w_beats_nxt;
   logic                w_aborted_nxt;
   logic                w_accept;
   logic                w_ldinit_en;
   logic                w_beat;
   logic                w_ready;
`ifdef AGU_SEQ_CLEAR_EN
   logic                w_clear;
`endif

   // r_out_en holds tr_ready low while reset is asserted so every output
   // reads 0 during reset and tr_ready rises the cycle after release.
   assign w_ready = (r_state == ST_IDLE) && r_out_en;

   // Next-state, beat counting and strobe qualification.
   always_comb begin
      w_state_nxt   = r_state;
      w_beats_nxt   = r_beats_left;
      w_aborted_nxt = r_aborted;
      w_accept      = 1'b0;
      w_ldinit_en   = 1'b0;
      w_beat        = 1'b0;
`ifdef AGU_SEQ_CLEAR_EN
      w_clear       = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (tr_valid && w_ready) begin
               w_accept      = 1'b1;
               w_beats_nxt   = tr_length;
               w_aborted_nxt = 1'b0;
`ifdef AGU_SEQ_CLEAR_EN
               w_state_nxt   = ST_CLEAR;
`else
               w_state_nxt   = ST_LOAD;
`endif
            end
         end
`ifdef AGU_SEQ_CLEAR_EN
         ST_CLEAR: begin
            w_clear     = 1'b1;
            w_state_nxt = ST_LOAD;
         end
`endif
         ST_LOAD: begin
            if (abort) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = ST_DONE;
            end else begin
               w_ldinit_en = 1'b1;
               w_state_nxt = (r_beats_left != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            // abort wins over the final beat and freezes the count
            if (abort) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = ST_DONE;
            end else if (!agu_stall) begin
               w_beat      = 1'b1;
               w_beats_nxt = r_beats_left - LEN_W'(1);
               if (r_beats_left == LEN_W'(1)) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
`ifdef AGU_SEQ_CLEAR_EN
            w_clear     = r_aborted;
`endif
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Descriptor capture, beat counter and abort flag.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_out_en     <= 1'b0;
         r_aborted    <= 1'b0;
         r_latch_addr <= '0;
         r_latch_ctrl <= '0;
         r_beats_left <= '0;
      end else begin
         r_out_en     <= 1'b1;
         r_aborted    <= w_aborted_nxt;
         r_beats_left <= w_beats_nxt;
         if (w_accept) begin
            r_latch_addr <= tr_addresses;
            r_latch_ctrl <= tr_control;
         end
      end
   end

   assign tr_ready           = w_ready;
   assign latch_tr_addresses = r_latch_addr;
   assign latch_tr_control   = r_latch_ctrl;
   assign beats_left         = r_beats_left;
   assign busy               = (r_state != ST_IDLE);
   assign done               = (r_state == ST_DONE);
   assign aborted            = (r_state == ST_DONE) && r_aborted;

   // fb generator has no ldinit; ldinit and enable come from different states
   assign mem_gen_ldinit  = w_ldinit_en & r_latch_ctrl[0];
   assign byte_gen_ldinit = w_ldinit_en & r_latch_ctrl[1];
   assign rc_gen_ldinit   = w_ldinit_en & r_latch_ctrl[3];

   assign mem_gen_enable  = w_beat & r_latch_ctrl[0];
   assign byte_gen_enable = w_beat & r_latch_ctrl[1];
   assign fb_gen_enable   = w_beat & r_latch_ctrl[2];
   assign rc_gen_enable   = w_beat & r_latch_ctrl[3];

`ifdef AGU_SEQ_CLEAR_EN
   assign clear_agu = w_clear;
`else
   assign clear_agu = 1'b0;
`endif

endmodule

// File: tb/tb_agu_sequencer.sv
// Directed bench for agu_sequencer. Inputs change on the falling edge,
// outputs are observed 1 ns later; cycle offsets count from the cycle in
// which the descriptor is presented (offset 0).

module tb_agu_sequencer;

`ifdef AGU_SEQ_CLEAR_EN
   localparam int XL = 1;
`else
   localparam int XL = 0;
`endif

   logic        sys_clk;
   logic        sys_rst_n;
   logic        tr_valid;
   logic        tr_ready;
   logic [39:0] tr_addresses;
   logic [3:0]  tr_control;
   logic [15:0] tr_length;
   logic        agu_stall;
   logic        abort;
   logic [39:0] latch_tr_addresses;
   logic [3:0]  latch_tr_control;
   logic        mem_gen_ldinit, byte_gen_ldinit, rc_gen_ldinit;
   logic        mem_gen_enable, byte_gen_enable, fb_gen_enable, rc_gen_enable;
   logic        clear_agu;
   logic        busy;
   logic [15:0] beats_left;
   logic        done;
   logic        aborted;

   int n_checks = 0;
   int n_fail   = 0;

   // observations gathered by xfer
   bit          o_acc;
   int          o_ld_m, o_ld_b, o_ld_r;
   int          o_en_m, o_en_b, o_en_f, o_en_r;
   int          o_done_off, o_first_en, o_last_en;
   int          o_clr_cnt, o_clr_off;
   int          o_overlap, o_latch_bad, o_ready_busy;
   logic        o_aborted;
   logic [15:0] o_bl_end;

   agu_sequencer #(.ADDR_W(40), .CTRL_W(4), .LEN_W(16)) dut (
      .sys_clk            (sys_clk),
      .sys_rst_n          (sys_rst_n),
      .tr_valid           (tr_valid),
      .tr_ready           (tr_ready),
      .tr_addresses       (tr_addresses),
      .tr_control         (tr_control),
      .tr_length          (tr_length),
      .agu_stall          (agu_stall),
      .abort              (abort),
      .latch_tr_addresses (latch_tr_addresses),
      .latch_tr_control   (latch_tr_control),
      .mem_gen_ldinit     (mem_gen_ldinit),
      .byte_gen_ldinit    (byte_gen_ldinit),
      .rc_gen_ldinit      (rc_gen_ldinit),
      .mem_gen_enable     (mem_gen_enable),
      .byte_gen_enable    (byte_gen_enable),
      .fb_gen_enable      (fb_gen_enable),
      .rc_gen_enable      (rc_gen_enable),
      .clear_agu          (clear_agu),
      .busy               (busy),
      .beats_left         (beats_left),
      .done               (done),
      .aborted            (aborted)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(negedge sys_clk);
   endtask

   // Presents one descriptor and records what the DUT does until done
   // (bounded to 64 cycles; o_done_off stays -1 if done never appears).
   task automatic xfer(input logic [39:0] addr, input logic [3:0] ctrl,
                       input logic [15:0] len, input logic [63:0] stall_vec,
                       input int abort_off, input bit hold_valid);
      o_ld_m = 0; o_ld_b = 0; o_ld_r = 0;
      o_en_m = 0; o_en_b = 0; o_en_f = 0; o_en_r = 0;
      o_done_off = -1; o_first_en = -1; o_last_en = -1;
      o_clr_cnt = 0; o_clr_off = -1;
      o_overlap = 0; o_latch_bad = 0; o_ready_busy = 0;
      o_aborted = 1'bx; o_bl_end = 'x;
      tr_valid = 1'b1; tr_addresses = addr; tr_control = ctrl; tr_length = len;
      agu_stall = stall_vec[0]; abort = (abort_off == 0);
      #1;
      o_acc = tr_ready;
      for (int off = 1; off < 64 && o_done_off < 0; off++) begin
         tick();
         tr_valid = hold_valid;
         tr_addresses = ~addr;
         tr_control = ~ctrl;
         tr_length = len + 16'd7;
         agu_stall = stall_vec[off];
         abort = (abort_off == off);
         #1;
         if ((mem_gen_ldinit | byte_gen_ldinit | rc_gen_ldinit) &&
             (mem_gen_enable | byte_gen_enable | fb_gen_enable | rc_gen_enable))
            o_overlap++;
         o_ld_m += int'(mem_gen_ldinit);
         o_ld_b += int'(byte_gen_ldinit);
         o_ld_r += int'(rc_gen_ldinit);
         o_en_m += int'(mem_gen_enable);
         o_en_b += int'(byte_gen_enable);
         o_en_f += int'(fb_gen_enable);
         o_en_r += int'(rc_gen_enable);
         if (mem_gen_enable | byte_gen_enable | fb_gen_enable | rc_gen_enable) begin
            if (o_first_en < 0) o_first_en = off;
            o_last_en = off;
         end
         if (clear_agu) begin
            o_clr_cnt++;
            if (o_clr_off < 0) o_clr_off = off;
         end
         if (latch_tr_addresses !== addr || latch_tr_control !== ctrl) o_latch_bad++;
         if (tr_ready) o_ready_busy++;
         if (done) begin
            o_done_off = off;
            o_aborted = aborted;
            o_bl_end = beats_left;
         end
      end
      tick();
      tr_valid = 1'b0; agu_stall = 1'b0; abort = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; tr_valid = 1'b0; tr_addresses = '0; tr_control = '0;
      tr_length = '0; agu_stall = 1'b0; abort = 1'b0;
      tick(); tick(); #1;
      n_checks++;
      if ({tr_ready, busy, done, aborted, clear_agu, latch_tr_addresses, latch_tr_control, beats_left} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got ready=%0b busy=%0b done=%0b addr=%h ctrl=%h beats=%0d, required all 0",
                            tr_ready, busy, done, latch_tr_addresses, latch_tr_control, beats_left);
      end
      tick(); sys_rst_n = 1'b1;
      tick(); #1;
      n_checks++;
      if (tr_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got ready=%0b busy=%0b, required ready=1 busy=0", tr_ready, busy);
      end
   endtask

   task automatic test_single();
      tick();
      xfer(40'h0012345678, 4'b1111, 16'd3, 64'd0, -1, 1'b0);
      n_checks++;
      if (o_acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %0b required 1", o_acc); end
      n_checks++;
      if (o_ld_m !== 1 || o_ld_b !== 1 || o_ld_r !== 1) begin
         n_fail++; $display("FAIL single_ldinit: got m=%0d b=%0d r=%0d required 1 1 1", o_ld_m, o_ld_b, o_ld_r);
      end
      n_checks++;
      if (o_en_m !== 3 || o_en_b !== 3 || o_en_f !== 3 || o_en_r !== 3) begin
         n_fail++; $display("FAIL single_enables: got m=%0d b=%0d f=%0d r=%0d required 3 each", o_en_m, o_en_b, o_en_f, o_en_r);
      end
      n_checks++;
      if (o_first_en !== 2 + XL || o_last_en !== 4 + XL) begin
         n_fail++; $display("FAIL single_en_window: got %0d..%0d required %0d..%0d", o_first_en, o_last_en, 2 + XL, 4 + XL);
      end
      n_checks++;
      if (o_done_off !== 5 + XL || o_aborted !== 1'b0 || o_bl_end !== 16'd0) begin
         n_fail++; $display("FAIL single_done: got off=%0d aborted=%0b beats=%0d required off=%0d aborted=0 beats=0",
                            o_done_off, o_aborted, o_bl_end, 5 + XL);
      end
      n_checks++;
      if (o_overlap !== 0 || o_latch_bad !== 0 || o_ready_busy !== 0) begin
         n_fail++; $display("FAIL single_hygiene: got overlap=%0d latch_bad=%0d ready_busy=%0d required 0 0 0",
                            o_overlap, o_latch_bad, o_ready_busy);
      end
      n_checks++;
      if (o_clr_cnt !== XL || (XL == 1 && o_clr_off !== 1)) begin
         n_fail++; $display("FAIL single_clear: got cnt=%0d off=%0d required cnt=%0d off=1", o_clr_cnt, o_clr_off, XL);
      end
   endtask

   task automatic test_stall();
      logic [63:0] sv;
      sv = 64'b11 << (3 + XL);
      xfer(40'h00A5A5A5A5, 4'b0001, 16'd4, sv, -1, 1'b0);
      n_checks++;
      if (o_en_m !== 4 || o_en_b !== 0 || o_en_f !== 0 || o_en_r !== 0) begin
         n_fail++; $display("FAIL stall_enables: got m=%0d b=%0d f=%0d r=%0d required 4 0 0 0", o_en_m, o_en_b, o_en_f, o_en_r);
      end
      n_checks++;
      if (o_first_en !== 2 + XL || o_last_en !== 7 + XL || o_done_off !== 8 + XL) begin
         n_fail++; $display("FAIL stall_timing: got en %0d..%0d done %0d required %0d..%0d done %0d",
                            o_first_en, o_last_en, o_done_off, 2 + XL, 7 + XL, 8 + XL);
      end
      n_checks++;
      if (o_ld_m !== 1 || o_ld_b !== 0 || o_ld_r !== 0) begin
         n_fail++; $display("FAIL stall_ldinit: got m=%0d b=%0d r=%0d required 1 0 0", o_ld_m, o_ld_b, o_ld_r);
      end
   endtask

   task automatic test_zero_len();
      xfer(40'h0000000001, 4'b1010, 16'd0, 64'd0, -1, 1'b0);
      n_checks++;
      if (o_ld_m !== 0 || o_ld_b !== 1 || o_ld_r !== 1) begin
         n_fail++; $display("FAIL zero_ldinit: got m=%0d b=%0d r=%0d required 0 1 1", o_ld_m, o_ld_b, o_ld_r);
      end
      n_checks++;
      if (o_en_m + o_en_b + o_en_f + o_en_r !== 0 || o_done_off !== 2 + XL || o_aborted !== 1'b0) begin
         n_fail++; $display("FAIL zero_done: got enables=%0d done_off=%0d aborted=%0b required 0 %0d 0",
                            o_en_m + o_en_b + o_en_f + o_en_r, o_done_off, 2 + XL, o_aborted);
      end
   endtask

   task automatic test_abort();
      xfer(40'hFEDCBA9876, 4'b1111, 16'd5, 64'd0, 3 + XL, 1'b0);
      n_checks++;
      if (o_en_m !== 1 || o_en_f !== 1 || o_overlap !== 0) begin
         n_fail++; $display("FAIL abort_beats: got m=%0d f=%0d overlap=%0d required 1 1 0", o_en_m, o_en_f, o_overlap);
      end
      n_checks++;
      if (o_done_off !== 4 + XL || o_aborted !== 1'b1 || o_bl_end !== 16'd4) begin
         n_fail++; $display("FAIL abort_done: got off=%0d aborted=%0b beats=%0d required off=%0d aborted=1 beats=4",
                            o_done_off, o_aborted, o_bl_end, 4 + XL);
      end
      n_checks++;
      if (o_clr_cnt !== 2 * XL) begin
         n_fail++; $display("FAIL abort_clear: got %0d required %0d", o_clr_cnt, 2 * XL);
      end
      xfer(40'h0000001234, 4'b0100, 16'd1, 64'd0, -1, 1'b0);
      n_checks++;
      if (o_acc !== 1'b1 || o_en_f !== 1 || o_done_off !== 3 + XL || o_aborted !== 1'b0) begin
         n_fail++; $display("FAIL abort_next: got acc=%0b fb=%0d done_off=%0d aborted=%0b required 1 1 %0d 0",
                            o_acc, o_en_f, o_done_off, 3 + XL, o_aborted);
      end
   endtask

   task automatic test_back_to_back();
      xfer(40'hABCDEF0123, 4'b0110, 16'd2, 64'd0, -1, 1'b1);
      n_checks++;
      if (o_latch_bad !== 0 || o_ready_busy !== 0) begin
         n_fail++; $display("FAIL b2b_hold: got latch_bad=%0d ready_busy=%0d required 0 0", o_latch_bad, o_ready_busy);
      end
      n_checks++;
      if (o_done_off !== 4 + XL || o_en_b !== 2 || o_en_f !== 2 || o_en_m !== 0) begin
         n_fail++; $display("FAIL b2b_first: got done_off=%0d b=%0d f=%0d m=%0d required %0d 2 2 0",
                            o_done_off, o_en_b, o_en_f, o_en_m, 4 + XL);
      end
      xfer(40'h1111222233, 4'b1001, 16'd1, 64'd0, -1, 1'b0);
      n_checks++;
      if (o_acc !== 1'b1 || o_en_m !== 1 || o_en_r !== 1 || o_done_off !== 3 + XL || o_latch_bad !== 0) begin
         n_fail++; $display("FAIL b2b_second: got acc=%0b m=%0d r=%0d done_off=%0d latch_bad=%0d required 1 1 1 %0d 0",
                            o_acc, o_en_m, o_en_r, o_done_off, o_latch_bad, 3 + XL);
      end
   endtask

   task automatic test_reset_mid_run();
      tr_valid = 1'b1; tr_addresses = 40'h5555AAAA55; tr_control = 4'b1111; tr_length = 16'd5;
      tick(); tr_valid = 1'b0;
      for (int i = 0; i < 2 + XL; i++) tick();
      sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_gen_enable !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_pre: got enable=%0b busy=%0b required 1 1", mem_gen_enable, busy);
      end
      tick(); #1;
      n_checks++;
      if ({tr_ready, busy, done, aborted, clear_agu, mem_gen_enable, byte_gen_enable, fb_gen_enable, rc_gen_enable,
           mem_gen_ldinit, byte_gen_ldinit, rc_gen_ldinit, latch_tr_addresses, latch_tr_control, beats_left} !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got busy=%0b done=%0b addr=%h ctrl=%h beats=%0d ready=%0b required all 0",
                            busy, done, latch_tr_addresses, latch_tr_control, beats_left, tr_ready);
      end
      tick(); sys_rst_n = 1'b1; #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0b required 0", done); end
      tick(); #1;
      n_checks++;
      if (tr_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_release: got ready=%0b busy=%0b required 1 0", tr_ready, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_zero_len();
      test_abort();
      test_back_to_back();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
